// File: rtl/free_list_if.sv
// Allocation and release channels between ID/ROB and the physical-register free list.
// id_valid/id_ready: a pop happens on a rising edge where both are high; commit_valid has no ready (release is never back-pressured).
interface free_list_if #(
    parameter int PHY_IDX_W = 6,
    parameter int CNT_W     = 6
);
    logic                 id_valid;
    logic                 id_ready;
    logic [PHY_IDX_W-1:0] id_free_idx;
    logic                 commit_valid;
    logic [PHY_IDX_W-1:0] commit_phy;
    logic [CNT_W-1:0]     free_count;
    logic                 overflow_err;

    modport master (
        output id_valid, commit_valid, commit_phy,
        input  id_ready, id_free_idx, free_count, overflow_err
    );

    modport slave (
        input  id_valid, commit_valid, commit_phy,
        output id_ready, id_free_idx, free_count, overflow_err
    );
endinterface

// File: rtl/free_list.sv
// Circular FIFO of free physical register indices: ID pops at dispatch, ROB pushes stale registers at commit.
// Pointers carry an extra wrap bit so full and empty are distinguishable when the index bits match.
module free_list #(
    parameter int N_PHY_REGS      = 64,
    parameter int N_ARCH_REGS     = 32,
    parameter bit ASSERT_OVERFLOW = 1'b1
) (
    input logic        clk,
    input logic        rst,
    free_list_if.slave fl
);
    localparam int PHY_IDX_W = $clog2(N_PHY_REGS);
    localparam int FL_DEPTH  = N_PHY_REGS - N_ARCH_REGS;
    localparam int PTR_W     = $clog2(FL_DEPTH);
    localparam int CNT_W     = $clog2(FL_DEPTH + 1);

    typedef logic [PTR_W:0] ptr_t;

    logic [PHY_IDX_W-1:0] entries [FL_DEPTH];
    ptr_t                 head;
    ptr_t                 tail;
    logic [CNT_W-1:0]     count;
    logic                 ovf;
    logic                 full;
    logic                 pop;
    logic                 push_req;
    logic                 push;

    function automatic ptr_t ptr_inc(input ptr_t p);
        if (p[PTR_W-1:0] == PTR_W'(FL_DEPTH - 1))
            return {~p[PTR_W], {PTR_W{1'b0}}};
        else
            return p + ptr_t'(1);
    endfunction

    assign full     = (head[PTR_W-1:0] == tail[PTR_W-1:0]) && (head[PTR_W] != tail[PTR_W]);
    assign pop      = fl.id_valid && fl.id_ready;
    assign push_req = fl.commit_valid && (fl.commit_phy != '0);
    // A pop in the same cycle frees the slot the push needs, so full alone does not block it.
    assign push     = push_req && (!full || pop);

    assign fl.id_ready     = (count != '0);
    assign fl.id_free_idx  = entries[head[PTR_W-1:0]];
    assign fl.free_count   = count;
    assign fl.overflow_err = ovf;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FL_DEPTH; i++)
                entries[i] <= PHY_IDX_W'(N_ARCH_REGS + i);
            head  <= '0;
            tail  <= {1'b1, {PTR_W{1'b0}}};
            count <= CNT_W'(FL_DEPTH);
            ovf   <= 1'b0;
        end else begin
            if (pop)
                head <= ptr_inc(head);
            if (push) begin
                entries[tail[PTR_W-1:0]] <= fl.commit_phy;
                tail                     <= ptr_inc(tail);
            end
            if (push_req && !push)
                ovf <= 1'b1;
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (ASSERT_OVERFLOW && rst)
            assert (!(push_req && !push))
            else $error("free_list: release of p%0d while full was dropped", fl.commit_phy);
    end
endmodule

// File: tb/tb_free_list.sv
// Randomised and directed stimulus for free_list, checked against a queue-based model of the free pool.
module tb_free_list;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    free_list_if #(.PHY_IDX_W(6), .CNT_W(6)) fl();

    free_list #(
        .N_PHY_REGS(64),
        .N_ARCH_REGS(32),
        .ASSERT_OVERFLOW(1'b0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .fl(fl)
    );

    // Packed observation: {overflow_err, id_ready, free_count, id_free_idx or 0 when not ready}
    logic [13:0] exp_q[$];
    logic [5:0]  model_q[$];
    logic        model_ovf;
    int          checks = 0;
    int          passes = 0;

    function automatic logic [13:0] model_word();
        logic rdy;
        rdy = (model_q.size() != 0);
        return {model_ovf, rdy, 6'(model_q.size()), rdy ? model_q[0] : 6'd0};
    endfunction

    function automatic logic [13:0] dut_word();
        return {fl.overflow_err, fl.id_ready, fl.free_count, fl.id_ready ? fl.id_free_idx : 6'd0};
    endfunction

    task automatic reset_model();
        model_q.delete();
        for (int i = 0; i < 32; i++)
            model_q.push_back(6'(32 + i));
        model_ovf = 1'b0;
    endtask

    task automatic compare(input string name, input logic [13:0] act, input logic [13:0] exp);
        checks++;
        if (act === exp)
            passes++;
        else
            $display("FAIL %s: got ovf=%0b rdy=%0b cnt=%0d idx=%0d, expected ovf=%0b rdy=%0b cnt=%0d idx=%0d",
                     name, act[13], act[12], act[11:6], act[5:0], exp[13], exp[12], exp[11:6], exp[5:0]);
    endtask

    // One clock of stimulus; the model applies the same edge and queues the state expected after it.
    task automatic cycle(input logic v, input logic cv, input logic [5:0] cp);
        logic was_ready;
        logic was_full;
        fl.id_valid     = v;
        fl.commit_valid = cv;
        fl.commit_phy   = cp;
        @(posedge clk);
        was_ready = (model_q.size() != 0);
        was_full  = (model_q.size() == 32);
        if (v && was_ready)
            void'(model_q.pop_front());
        if (cv && cp != 6'd0) begin
            if (!was_full || (v && was_ready))
                model_q.push_back(cp);
            else
                model_ovf = 1'b1;
        end
        exp_q.push_back(model_word());
        #2;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0)
            compare("cycle", dut_word(), exp_q.pop_front());
    end

    initial begin
        fl.id_valid     = 1'b0;
        fl.commit_valid = 1'b0;
        fl.commit_phy   = 6'd0;
        reset_model();
        #12 rst = 1'b1;
        #1 compare("reset", dut_word(), model_word());

        // Drain to empty, then one request that must be ignored
        repeat (33) cycle(1'b1, 1'b0, 6'd0);

        // Refill from empty: no bypass, ready only after the push edge
        cycle(1'b0, 1'b1, 6'd5);
        cycle(1'b0, 1'b1, 6'd9);
        cycle(1'b1, 1'b0, 6'd0);
        cycle(1'b0, 1'b1, 6'd7);
        cycle(1'b0, 1'b1, 6'd11);
        cycle(1'b1, 1'b1, 6'd40);

        // Wrap-around: empty, refill in a chosen order, drain again
        repeat (4) cycle(1'b1, 1'b0, 6'd0);
        for (int i = 0; i < 32; i++)
            cycle(1'b0, 1'b1, (i < 31) ? 6'(33 + i) : 6'd1);
        repeat (32) cycle(1'b1, 1'b0, 6'd0);

        // Fill, then overflow, p0 release, and push+pop while full
        for (int i = 0; i < 32; i++)
            cycle(1'b0, 1'b1, 6'(i + 2));
        cycle(1'b0, 1'b1, 6'd50);
        cycle(1'b0, 1'b1, 6'd0);
        cycle(1'b1, 1'b1, 6'd51);
        cycle(1'b0, 1'b1, 6'd0);
        repeat (3) cycle(1'b1, 1'b0, 6'd0);

        repeat (400)
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)));

        // Asynchronous reset mid-stream with active requests
        fl.id_valid     = 1'b1;
        fl.commit_valid = 1'b1;
        fl.commit_phy   = 6'd3;
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        reset_model();
        compare("async_reset", dut_word(), model_word());
        fl.id_valid     = 1'b0;
        fl.commit_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;

        repeat (60)
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)));

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() == 0)
            passes++;
        else
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
